// File: rtl/adc083000_spi_rx.sv
// Target end of the ADC083000 3-wire configuration write path: deserializes
// {header, addr, data} frames framed by chip_sel and mirrors them in a 16x16 register file.
module adc083000_spi_rx #(
   parameter logic [11:0] HEADER      = 12'h001,
   parameter int          LEAD_CYCLES = 1,
   parameter logic [15:0] RESET_VALUE = 16'h0000
) (
   input  logic        sclk,
   input  logic        reset,
   input  logic        sdata,
   input  logic        chip_sel,
   input  logic [3:0]  rd_addr,
   output logic [15:0] rd_data,
   output logic        wr_valid,
   output logic [3:0]  wr_addr,
   output logic [15:0] wr_data,
   output logic        hdr_err,
   output logic        short_err,
   output logic        ovr_err,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LEAD  = 3'd1,
      SHIFT = 3'd2,
      DONE  = 3'd3,
      OVR   = 3'd4
   } state_t;

   // The IDLE edge that first sees chip_sel counts as the first ignored lead edge,
   // so bit 31 lands on edge LEAD_CYCLES+1 for every legal LEAD_CYCLES.
   localparam logic [1:0] LEAD_LAST = (LEAD_CYCLES > 0) ? 2'(LEAD_CYCLES - 1) : 2'd0;

   state_t      state;
   logic [31:0] sr;
   logic [5:0]  bit_cnt;
   logic [1:0]  lead_cnt;
   logic [15:0] regs [16];
   logic        commit_ok;

   assign commit_ok = (state == DONE) && !chip_sel && (sr[31:20] == HEADER);

   always_ff @(posedge sclk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         sr        <= '0;
         bit_cnt   <= '0;
         lead_cnt  <= '0;
         wr_valid  <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         hdr_err   <= 1'b0;
         short_err <= 1'b0;
         ovr_err   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         wr_valid  <= 1'b0;
         hdr_err   <= 1'b0;
         short_err <= 1'b0;
         ovr_err   <= 1'b0;
         case (state)
            IDLE: begin
               bit_cnt  <= '0;
               lead_cnt <= '0;
               if (chip_sel) begin
                  busy <= 1'b1;
                  if (LEAD_CYCLES == 0) begin
                     sr      <= {sr[30:0], sdata};
                     bit_cnt <= 6'd1;
                     state   <= SHIFT;
                  end else begin
                     state <= LEAD;
                  end
               end
            end
            LEAD: begin
               if (!chip_sel) begin
                  short_err <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end else begin
                  lead_cnt <= lead_cnt + 2'd1;
                  if (lead_cnt == LEAD_LAST) begin
                     sr      <= {sr[30:0], sdata};
                     bit_cnt <= 6'd1;
                     state   <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               if (!chip_sel) begin
                  short_err <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end else begin
                  sr <= {sr[30:0], sdata};
                  if (bit_cnt != 6'd32) bit_cnt <= bit_cnt + 6'd1;
                  if (bit_cnt == 6'd31) state <= DONE;
               end
            end
            DONE: begin
               if (!chip_sel) begin
                  busy  <= 1'b0;
                  state <= IDLE;
                  if (sr[31:20] == HEADER) begin
                     wr_valid <= 1'b1;
                     wr_addr  <= sr[19:16];
                     wr_data  <= sr[15:0];
                  end else begin
                     hdr_err <= 1'b1;
                  end
               end else begin
                  state <= OVR;
               end
            end
            OVR: begin
               if (!chip_sel) begin
                  ovr_err <= 1'b1;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Write lands on the commit edge; rd_data shows the old value until then (no bypass).
   always_ff @(posedge sclk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) regs[i] <= RESET_VALUE;
      end else if (commit_ok) begin
         regs[sr[19:16]] <= sr[15:0];
      end
   end

   assign rd_data = regs[rd_addr];

endmodule

// File: tb/tb_adc083000_spi_rx.sv
// Directed bench for adc083000_spi_rx: frames are driven serially, expected
// write/error events queue in exp_q and are matched as the receiver reports them.
module tb_adc083000_spi_rx;

   localparam logic [15:0] RV = 16'h0000;

   logic        sclk = 1'b0;
   logic        reset = 1'b1;
   logic        sdata = 1'b0;
   logic        chip_sel = 1'b0;
   logic [3:0]  rd_addr = 4'd0;
   logic [15:0] rd_data;
   logic        wr_valid;
   logic [3:0]  wr_addr;
   logic [15:0] wr_data;
   logic        hdr_err;
   logic        short_err;
   logic        ovr_err;
   logic        busy;

   int checks = 0;
   int errors = 0;

   // Event code: {ovr, short, hdr, wr, addr[3:0], data[15:0]}
   logic [23:0] exp_q[$];
   logic [15:0] model_regs [16];
   logic [3:0]  exp_wr_addr = 4'd0;
   logic [15:0] exp_wr_data = 16'h0000;

   adc083000_spi_rx dut (
      .sclk      (sclk),
      .reset     (reset),
      .sdata     (sdata),
      .chip_sel  (chip_sel),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .wr_valid  (wr_valid),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .hdr_err   (hdr_err),
      .short_err (short_err),
      .ovr_err   (ovr_err),
      .busy      (busy)
   );

   always #5 sclk = ~sclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: every reported pulse is one event, matched against the queue head.
   always @(negedge sclk) begin
      if (!reset && (wr_valid || hdr_err || short_err || ovr_err)) begin
         logic [23:0] obs;
         obs = {ovr_err, short_err, hdr_err, wr_valid,
                wr_valid ? {wr_addr, wr_data} : 20'h0};
         if (exp_q.size() == 0) begin
            check("unexpected_event", {8'h0, obs}, 32'h0);
         end else begin
            check("event", {8'h0, obs}, {8'h0, exp_q.pop_front()});
         end
      end
   end

   // Called just after a falling edge; leaves just after the falling edge
   // following the single low cycle, so back-to-back calls give one low cycle.
   task automatic send_frame(input logic [31:0] f, input int nbits, input string tag);
      if (nbits < 32) begin
         exp_q.push_back({4'b0100, 20'h0});
      end else if (nbits > 32) begin
         exp_q.push_back({4'b1000, 20'h0});
      end else if (f[31:20] == 12'h001) begin
         exp_q.push_back({4'b0001, f[19:0]});
         model_regs[f[19:16]] = f[15:0];
         exp_wr_addr = f[19:16];
         exp_wr_data = f[15:0];
      end else begin
         exp_q.push_back({4'b0010, 20'h0});
      end
      for (int c = 0; c <= nbits; c++) begin
         chip_sel = 1'b1;
         sdata = (c >= 1 && c <= 32) ? f[32 - c] : 1'($urandom_range(0, 1));
         @(negedge sclk); #1;
         if (c == 3) check({tag, "_busy_mid"}, {31'h0, busy}, 32'h1);
      end
      chip_sel = 1'b0;
      sdata = 1'b0;
      @(negedge sclk); #1;
      // The event must already have been reported one sclk after chip_sel fell.
      check({tag, "_latency"}, exp_q.size(), 32'h0);
      exp_q.delete();
      check({tag, "_wr_addr"}, {28'h0, wr_addr}, {28'h0, exp_wr_addr});
      check({tag, "_wr_data"}, {16'h0, wr_data}, {16'h0, exp_wr_data});
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i);
         #1;
         check($sformatf("%s_reg%0d", tag, i), {16'h0, rd_data}, {16'h0, model_regs[i]});
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) model_regs[i] = RV;

      // Reset state
      repeat (3) @(negedge sclk);
      #1;
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_pulses", {28'h0, wr_valid, hdr_err, short_err, ovr_err}, 32'h0);
      check("rst_wr_addr", {28'h0, wr_addr}, 32'h0);
      check("rst_wr_data", {16'h0, wr_data}, 32'h0);
      check_regs("rst");
      reset = 1'b0;
      @(negedge sclk); #1;
      check("idle_busy", {31'h0, busy}, 32'h0);

      // Nominal write
      send_frame({12'h001, 4'h3, 16'hA5C3}, 32, "nominal");
      check("nominal_busy_after", {31'h0, busy}, 32'h0);
      check_regs("nominal");

      // Bad header: no write, wr_addr/wr_data hold
      @(negedge sclk); #1;
      send_frame({12'h002, 4'h5, 16'h1234}, 32, "badhdr");
      check_regs("badhdr");

      // Short frame then a good frame to the top address
      @(negedge sclk); #1;
      send_frame({12'h001, 4'h6, 16'h5555}, 20, "short");
      @(negedge sclk); #1;
      send_frame({12'h001, 4'hF, 16'hFFFF}, 32, "after_short");
      check_regs("after_short");

      // Lead-only frame is also short
      @(negedge sclk); #1;
      send_frame({12'h001, 4'h4, 16'h4444}, 0, "lead_only");

      // Overrun: 34 data bits
      @(negedge sclk); #1;
      send_frame({12'h001, 4'h9, 16'h9999}, 34, "overrun");
      check_regs("overrun");

      // Back-to-back with a single low cycle
      @(negedge sclk); #1;
      send_frame({12'h001, 4'h1, 16'h0001}, 32, "b2b_a");
      send_frame({12'h001, 4'h2, 16'hBEEF}, 32, "b2b_b");
      check_regs("b2b");

      // Random-data good frames
      for (int k = 0; k < 4; k++) begin
         logic [31:0] f;
         f = {12'h001, 4'($urandom_range(0, 15)), 16'($urandom_range(0, 65535))};
         @(negedge sclk); #1;
         send_frame(f, 32, $sformatf("rand%0d", k));
      end
      check_regs("rand");

      // Reset mid-frame at data bit 10
      @(negedge sclk); #1;
      for (int c = 0; c <= 10; c++) begin
         chip_sel = 1'b1;
         sdata = (c >= 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         @(negedge sclk); #1;
      end
      reset = 1'b1;
      #1;
      chip_sel = 1'b0;
      for (int i = 0; i < 16; i++) model_regs[i] = RV;
      exp_wr_addr = 4'd0;
      exp_wr_data = 16'h0;
      check("midrst_busy", {31'h0, busy}, 32'h0);
      check("midrst_wr_addr", {28'h0, wr_addr}, 32'h0);
      check("midrst_wr_data", {16'h0, wr_data}, 32'h0);
      check_regs("midrst");
      @(negedge sclk); #1;
      reset = 1'b0;
      repeat (2) @(negedge sclk);
      #1;
      check("midrst_no_pulse", {28'h0, wr_valid, hdr_err, short_err, ovr_err}, 32'h0);
      check("midrst_busy_idle", {31'h0, busy}, 32'h0);
      send_frame({12'h001, 4'h7, 16'h00C0}, 32, "post_rst");
      check_regs("post_rst");

      repeat (3) @(negedge sclk);
      check("queue_drained", exp_q.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout observed=running expected=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/adc083000_spi_rx.md
# adc083000_spi_rx

Serial-configuration receiver for the ADC083000 control path: the target end of the 3-wire write interface driven by the ADC083000 configuration serializer. It samples `sdata` framed by `chip_sel` on `sclk` and decodes the 32-bit frame {12-bit header, 4-bit address, 16-bit data}. Valid frames are committed into a 16 x 16-bit shadow register file with a combinational read port. It serves as the synthesizable ADC-side model for loopback self-test and as the register mirror in simulation benches.

## Interface
- `HEADER`, 12'h001, required header pattern (frame bits 31:20)
- `LEAD_CYCLES`, 1, `sclk` cycles after `chip_sel` rises that are ignored before bit 31 is sampled (range 0..3)
- `RESET_VALUE`, 16'h0000, reset contents of every register-file entry

Ports:
- `sclk` input 1: clock; all sampling on rising edge
- `reset` input 1: asynchronous, active-high
- `sdata` input 1: serial data, MSB first
- `chip_sel` input 1: frame select, active-high
- `rd_addr` input 4: register-file read address
- `rd_data` output 16: `regs[rd_addr]`, combinational
- `wr_valid` output 1: one-cycle pulse, frame committed
- `wr_addr` output 4: address of last committed frame
- `wr_data` output 16: data of last committed frame
- `hdr_err` output 1: one-cycle pulse, 32 bits received but header != `HEADER`
- `short_err` output 1: one-cycle pulse, `chip_sel` dropped before 32 bits
- `ovr_err` output 1: one-cycle pulse, `chip_sel` held after 32 bits
- `busy` output 1: state != IDLE

## Operation
- Shift register `sr[31:0]` loads as `sr <= {sr[30:0], sdata}` on each SHIFT-state edge. 6-bit `bit_cnt` counts from 0 and saturates at 32.
- **IDLE:** `bit_cnt <= 0`, `lead_cnt <= 0`.
  - `chip_sel==1`: if `LEAD_CYCLES==0`, go to SHIFT and sample bit 31 on this same edge; otherwise go to LEAD.
- **LEAD:** `lead_cnt` increments each edge.
  - `chip_sel==0`: pulse `short_err`, go to IDLE.
  - `lead_cnt` reaches `LEAD_CYCLES`: go to SHIFT. Default 1 matches the serializer's load cycle, where `sdata` is invalid.
- **SHIFT:** each edge with `chip_sel==1` shifts one bit and increments `bit_cnt`.
  - After the 32nd bit, go to DONE.
  - `chip_sel==0` with `bit_cnt<32`: pulse `short_err`, discard, go to IDLE.
- **DONE:**
  - `chip_sel==0`: commit, go to IDLE.
    - `sr[31:20]==HEADER`: write `regs[sr[19:16]] <= sr[15:0]`, load `wr_addr`/`wr_data`, pulse `wr_valid`.
    - Otherwise: pulse `hdr_err`; no write; `wr_addr`/`wr_data` hold.
  - `chip_sel==1`: go to OVR.
- **OVR:** ignore `sdata`. On `chip_sel==0`, pulse `ovr_err`, discard, go to IDLE.
- Only one error pulse per frame. `wr_valid` is never asserted in the same cycle as any error pulse.
- Back-to-back frames: the edge that commits (DONE to IDLE) requires `chip_sel` low. `chip_sel` high on the next edge starts a new frame, so one low cycle between frames is sufficient.
- Register-file write and `rd_data`: same-cycle write and read to the same address returns the old value until the write edge, then the new value. No bypass required.

## Timing
- Reset, asynchronous, any state:
  - state = IDLE, `sr` = 0, counters = 0
  - all pulses = 0, `busy` = 0
  - `wr_addr` = 0, `wr_data` = 0
  - every `regs[i]` = `RESET_VALUE`
- A reset mid-frame aborts the frame with no write and no error pulse.
- With default parameters, a frame is 33 high cycles of `chip_sel` (1 lead + 32 bits).
  - Bit 31 is sampled on the 2nd high edge; bit 0 on the 33rd.
  - `wr_valid` rises after the first edge that samples `chip_sel` low: one `sclk` after `chip_sel` falls.
- All status outputs are registered. `rd_data` is the only combinational output.
- `busy` rises after the edge that first samples `chip_sel==1` and falls after the edge that returns to IDLE.

## Test plan
- **Nominal write:** default lead, frame {12'h001, 4'h3, 16'hA5C3}, `chip_sel` high 33 cycles then low. Required: `wr_valid` pulses once with `wr_addr`=3 and `wr_data`=A5C3; `rd_addr`=3 gives A5C3; all other entries stay 0000.
- **Bad header:** frame {12'h002, 4'h5, 16'h1234}. Required: `hdr_err` pulses once, no `wr_valid`, `regs[5]`=0000.
- **Short frame:** `chip_sel` drops after 20 data bits. Required: `short_err` pulses once, no write; a following good frame {001, 4'hF, 16'hFFFF} commits normally.
- **Overrun:** 34 data bits (`chip_sel` high 35 cycles). Required: `ovr_err` pulses once after `chip_sel` falls, no write.
- **Back-to-back:** frames addr 1 data 0x0001 and addr 2 data 0xBEEF, separated by one low cycle. Required: two `wr_valid` pulses; `regs[1]`=0001 and `regs[2]`=BEEF.
- **Reset mid-frame:** assert `reset` at data bit 10, release, then send a good frame for addr 7 data 0x00C0. Required: no pulses from the aborted frame, all regs equal `RESET_VALUE`, then `regs[7]`=00C0.
